// File: rtl/mem_a_read_engine.sv
// Read engine for the A operand: pulls byte addresses from the show-ahead A address FIFO, issues
// one memory read per address, buffers the returned beats and streams them to the array feeder
// with a row index that cycles through the array height.
//
// Credit covers every request from the moment its address is popped until its beat leaves on the
// output handshake. The response buffer is therefore never overrun in normal operation. A beat
// that still arrives while the buffer is full is dropped and raises the sticky err_o.
//
// Ports
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   a_fifo_addr/empty/pop  show-ahead address FIFO interface
//   mem_req/addr/gnt       read request channel (request held until granted)
//   mem_rvalid/rdata       in-order read data return
//   row_data_o/valid_o/    output beat stream with valid/ready handshake
//   row_ready_i
//   row_index_o/last_o     row position of the current beat within its group
//   busy_o                 outstanding credit or a pending request
//   err_o                  sticky response-overflow flag
module mem_a_read_engine #(
  parameter int unsigned BUS_WIDTH_BYTES = 32,
  parameter int unsigned ARRAY_HEIGHT    = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [15:0]                      a_fifo_addr,
  input  logic                             a_fifo_empty,
  output logic                             a_fifo_pop,
  output logic                             mem_req,
  output logic [15:0]                      mem_addr,
  input  logic                             mem_gnt,
  input  logic                             mem_rvalid,
  input  logic [BUS_WIDTH_BYTES*8-1:0]     mem_rdata,
  output logic [BUS_WIDTH_BYTES*8-1:0]     row_data_o,
  output logic                             row_valid_o,
  input  logic                             row_ready_i,
  output logic [$clog2(ARRAY_HEIGHT)-1:0]  row_index_o,
  output logic                             row_last_o,
  output logic                             busy_o,
  output logic                             err_o
);

  localparam int unsigned DataW   = BUS_WIDTH_BYTES * 8;
  localparam int unsigned PtrW    = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CreditW = PtrW + 1;
  localparam int unsigned IdxW    = $clog2(ARRAY_HEIGHT);

  localparam logic [CreditW-1:0] MaxCredit = CreditW'(MAX_OUTSTANDING);
  localparam logic [IdxW-1:0]    LastIdx   = IdxW'(ARRAY_HEIGHT - 1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e               state_q, state_d;
  logic [15:0]          mem_addr_q, mem_addr_d;
  logic [CreditW-1:0]   credit_q, credit_d;
  logic [PtrW:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]        rd_ptr_q, rd_ptr_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 err_q, err_d;
  logic [DataW-1:0]     buf_q [MAX_OUTSTANDING];

  logic                 pop;
  logic                 out_hs;
  logic [CreditW-1:0]   credit_ret;
  logic                 room;
  logic                 buf_empty;
  logic                 buf_full;
  logic                 buf_wr;

  // ---------------------------------------------------------------------------------------------
  // Credit. A beat leaving this cycle frees its credit in time for a same-cycle pop, so a full
  // engine keeps issuing one request per drained beat.
  // ---------------------------------------------------------------------------------------------
  assign out_hs     = row_valid_o & row_ready_i;
  assign credit_ret = credit_q - {{PtrW{1'b0}}, out_hs};
  assign room       = credit_ret < MaxCredit;
  assign credit_d   = credit_q + {{PtrW{1'b0}}, pop} - {{PtrW{1'b0}}, out_hs};

  // ---------------------------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!a_fifo_empty && room) begin
          pop     = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_gnt) begin
          if (!a_fifo_empty && room) begin
            pop = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      mem_addr_d = a_fifo_addr;
    end
  end

  // The pop decode would otherwise see the reset-state FSM and a non-empty FIFO during reset.
  assign a_fifo_pop = pop & reset_n;
  assign mem_req    = (state_q == StReq);
  assign mem_addr   = mem_addr_q;

  // ---------------------------------------------------------------------------------------------
  // Response buffer: extra pointer bit separates full from empty.
  // ---------------------------------------------------------------------------------------------
  assign buf_empty = (wr_ptr_q == rd_ptr_q);
  assign buf_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  // When full, a same-cycle read frees the head slot, which is exactly the slot being written.
  assign buf_wr    = mem_rvalid & (~buf_full | out_hs);
  assign wr_ptr_d  = wr_ptr_q + {{PtrW{1'b0}}, buf_wr};
  assign rd_ptr_d  = rd_ptr_q + {{PtrW{1'b0}}, out_hs};
  assign err_d     = err_q | (mem_rvalid & buf_full & ~out_hs);
  assign idx_d     = out_hs ? idx_q + IdxW'(1) : idx_q;

  assign row_data_o  = buf_q[rd_ptr_q[PtrW-1:0]];
  assign row_valid_o = ~buf_empty;
  assign row_index_o = idx_q;
  assign row_last_o  = row_valid_o & (idx_q == LastIdx);
  assign busy_o      = (credit_q != '0) | mem_req;
  assign err_o       = err_q;

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      mem_addr_q <= '0;
      credit_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      credit_q   <= credit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
    end
  end

  // Data storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (buf_wr) begin
      buf_q[wr_ptr_q[PtrW-1:0]] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_a_read_engine.sv
// Bench for mem_a_read_engine: directed phases plus a randomized phase, all checked every cycle
// against a transaction-level reference model (address queue, beat queue, credit integer).
module tb_mem_a_read_engine;

  localparam int BW = 32;
  localparam int AH = 4;
  localparam int MO = 4;
  localparam int DW = BW * 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   a_fifo_addr = '0;
  logic          a_fifo_empty = 1'b1;
  logic          a_fifo_pop;
  logic          mem_req;
  logic [15:0]   mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] row_data_o;
  logic          row_valid_o;
  logic          row_ready_i = 1'b0;
  logic [1:0]    row_index_o;
  logic          row_last_o;
  logic          busy_o;
  logic          err_o;

  always #5 clk = ~clk;

  mem_a_read_engine #(
    .BUS_WIDTH_BYTES(BW),
    .ARRAY_HEIGHT   (AH),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .a_fifo_addr (a_fifo_addr),
    .a_fifo_empty(a_fifo_empty),
    .a_fifo_pop  (a_fifo_pop),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .row_data_o  (row_data_o),
    .row_valid_o (row_valid_o),
    .row_ready_i (row_ready_i),
    .row_index_o (row_index_o),
    .row_last_o  (row_last_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model
  logic [15:0]   fifo_q[$];
  logic [DW-1:0] m_buf[$];
  int            m_credit = 0;
  int            m_rows = 0;
  logic          m_pend = 1'b0;
  logic [15:0]   m_addr = '0;
  logic          m_err = 1'b0;
  // Memory: a beat granted in cycle N is returned in cycle N+2
  logic          pipe_v[2] = '{1'b0, 1'b0};
  logic [DW-1:0] pipe_d[2];
  logic          gnt_v = 1'b1;
  logic          ready_v = 1'b0;
  logic          inj_v = 1'b0;
  logic [DW-1:0] inj_d = '0;
  // Observation counters
  int pops_seen, reqs_seen, beats_seen, lasts_seen, last_beat;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat(input logic [15:0] addr);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    r[15:0] = addr;
    return r;
  endfunction

  task automatic clr_counts();
    pops_seen = 0; reqs_seen = 0; beats_seen = 0; lasts_seen = 0; last_beat = 0;
  endtask

  // Entered and left at a negedge; inputs change here, well away from the rising edge.
  task automatic cycle();
    logic          hs_m, pop_m, full_m, new_v;
    logic [DW-1:0] new_d;
    logic [DW-1:0] head;
    int            idx;
    a_fifo_empty = (fifo_q.size() == 0);
    a_fifo_addr  = a_fifo_empty ? 16'h0 : fifo_q[0];
    mem_gnt      = gnt_v;
    row_ready_i  = ready_v;
    mem_rvalid   = pipe_v[1] | inj_v;
    mem_rdata    = inj_v ? inj_d : pipe_d[1];
    #1;
    hs_m  = (m_buf.size() != 0) && ready_v;
    pop_m = (fifo_q.size() != 0) && (!m_pend || gnt_v) && ((m_credit - (hs_m ? 1 : 0)) < MO);
    idx   = m_rows % AH;
    head  = (m_buf.size() != 0) ? m_buf[0] : '0;
    chk("a_fifo_pop", DW'(a_fifo_pop), DW'(pop_m));
    chk("mem_req", DW'(mem_req), DW'(m_pend));
    if (m_pend) chk("mem_addr", DW'(mem_addr), DW'(m_addr));
    chk("row_valid", DW'(row_valid_o), DW'(m_buf.size() != 0));
    if (m_buf.size() != 0) chk("row_data", row_data_o, head);
    chk("row_index", DW'(row_index_o), DW'(idx));
    chk("row_last", DW'(row_last_o), DW'((m_buf.size() != 0) && (idx == AH - 1)));
    chk("busy", DW'(busy_o), DW'((m_credit != 0) || m_pend));
    chk("err", DW'(err_o), DW'(m_err));
    if (a_fifo_pop) pops_seen++;
    if (mem_req) reqs_seen++;
    if (row_last_o) lasts_seen++;
    if (row_valid_o && row_ready_i) begin
      beats_seen++;
      if (row_last_o) last_beat = beats_seen;
    end
    // Model update
    new_v = m_pend && gnt_v;
    new_d = new_v ? rand_beat(m_addr) : '0;
    if (pop_m) begin
      m_addr = fifo_q.pop_front();
      m_pend = 1'b1;
      m_credit++;
    end else if (m_pend && gnt_v) begin
      m_pend = 1'b0;
    end
    full_m = (m_buf.size() == MO);
    if (hs_m) begin
      void'(m_buf.pop_front());
      m_credit--;
      m_rows++;
    end
    if (mem_rvalid) begin
      if (!full_m || hs_m) m_buf.push_back(mem_rdata);
      else m_err = 1'b1;
    end
    pipe_v[1] = pipe_v[0];
    pipe_d[1] = pipe_d[0];
    pipe_v[0] = new_v;
    pipe_d[0] = new_d;
    inj_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_pop"}, DW'(a_fifo_pop), '0);
    chk({tag, "_req"}, DW'(mem_req), '0);
    chk({tag, "_addr"}, DW'(mem_addr), '0);
    chk({tag, "_valid"}, DW'(row_valid_o), '0);
    chk({tag, "_index"}, DW'(row_index_o), '0);
    chk({tag, "_last"}, DW'(row_last_o), '0);
    chk({tag, "_busy"}, DW'(busy_o), '0);
    chk({tag, "_err"}, DW'(err_o), '0);
  endtask

  task automatic do_reset(input int n);
    reset_n      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_gnt      = 1'b0;
    a_fifo_empty = (fifo_q.size() == 0);
    a_fifo_addr  = a_fifo_empty ? 16'h0 : fifo_q[0];
    #1;
    reset_check("rst_async");
    m_buf.delete();
    m_credit = 0; m_rows = 0; m_pend = 1'b0; m_addr = '0; m_err = 1'b0;
    pipe_v[0] = 1'b0; pipe_v[1] = 1'b0; inj_v = 1'b0;
    repeat (n) @(negedge clk);
    reset_check("rst_held");
    reset_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    logic done = 1'b0;
    gnt_v = 1'b1; ready_v = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      done = (fifo_q.size() == 0) && !m_pend && (m_buf.size() == 0) && !pipe_v[0] && !pipe_v[1];
      if (!done) cycle();
    end
    chk(tag, DW'(done), DW'(1));
  endtask

  task automatic burst4(input string tag);
    clr_counts();
    gnt_v = 1'b1; ready_v = 1'b1;
    repeat (14) cycle();
    chk({tag, "_pops"}, DW'(pops_seen), DW'(4));
    chk({tag, "_reqs"}, DW'(reqs_seen), DW'(4));
    chk({tag, "_beats"}, DW'(beats_seen), DW'(4));
    chk({tag, "_lasts"}, DW'(lasts_seen), DW'(1));
    chk({tag, "_last_beat"}, DW'(last_beat), DW'(4));
  endtask

  initial begin
    logic [DW-1:0] head;
    @(negedge clk);
    do_reset(2);

    // Basic 4-address burst
    fifo_q = '{16'h0000, 16'h0010, 16'h0020, 16'h0030};
    burst4("burst");

    // Credit limit with a stalled feeder, then a drain-one/pop-one at full credit and buffer
    clr_counts();
    for (int i = 0; i < 8; i++) fifo_q.push_back(16'($urandom));
    gnt_v = 1'b1; ready_v = 1'b0;
    repeat (20) cycle();
    chk("credit_pops", DW'(pops_seen), DW'(4));
    chk("credit_full_valid", DW'(row_valid_o), DW'(1));
    ready_v = 1'b1;
    cycle();
    chk("same_cycle_pops", DW'(pops_seen), DW'(5));
    ready_v = 1'b0;
    repeat (10) cycle();
    chk("one_more_pop", DW'(pops_seen), DW'(5));
    chk("no_err_full", DW'(err_o), DW'(0));
    drain("drain_credit");

    // Grant withheld for three cycles on the first request
    clr_counts();
    fifo_q.push_back(16'($urandom));
    fifo_q.push_back(16'($urandom));
    ready_v = 1'b1; gnt_v = 1'b1;
    cycle();
    gnt_v = 1'b0;
    repeat (3) cycle();
    chk("gnt_wait_pops", DW'(pops_seen), DW'(1));
    chk("gnt_wait_reqs", DW'(reqs_seen), DW'(3));
    gnt_v = 1'b1;
    cycle();
    chk("gnt_pops", DW'(pops_seen), DW'(2));
    chk("gnt_reqs", DW'(reqs_seen), DW'(4));
    drain("drain_gnt");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      gnt_v   = ($urandom_range(0, 3) != 0);
      ready_v = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 6) fifo_q.push_back(16'($urandom));
      cycle();
    end
    drain("drain_rand");

    // Overflow: injected beat with the buffer full and no read
    ready_v = 1'b0; gnt_v = 1'b1;
    for (int i = 0; i < 4; i++) fifo_q.push_back(16'($urandom));
    repeat (12) cycle();
    head = row_valid_o ? m_buf[0] : '0;
    inj_v = 1'b1;
    inj_d = rand_beat(16'hbeef);
    cycle();
    chk("ovf_err", DW'(err_o), DW'(1));
    chk("ovf_head", row_data_o, head);
    repeat (3) cycle();
    chk("ovf_sticky", DW'(err_o), DW'(1));

    // Reset mid-operation: two requests in flight, one beat buffered
    do_reset(2);
    ready_v = 1'b0; gnt_v = 1'b1;
    for (int i = 0; i < 3; i++) fifo_q.push_back(16'($urandom));
    repeat (4) cycle();
    chk("pre_rst_valid", DW'(row_valid_o), DW'(1));
    chk("pre_rst_busy", DW'(busy_o), DW'(1));
    fifo_q = '{16'h0000, 16'h0010, 16'h0020, 16'h0030};
    do_reset(2);
    burst4("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_a_read_engine.md
MEM_A_READ_ENGINE -- requirements
Module: mem_a_read_engine

Interface
REQ-001 Parameter BUS_WIDTH_BYTES, default 32, memory read data width in bytes.
REQ-002 Parameter ARRAY_HEIGHT, default 4, beats per row group; power of two, at least 2.
REQ-003 Parameter MAX_OUTSTANDING, default 4, maximum credit (in-flight requests plus buffered beats); power of two, at least 2.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 a_fifo_addr  input  16  head of the A address FIFO; valid while a_fifo_empty=0 (show-ahead).
REQ-007 a_fifo_empty  input  1  A address FIFO empty.
REQ-008 a_fifo_pop  output  1  consumes the FIFO head this cycle.
REQ-009 mem_req  output  1  read request valid.
REQ-010 mem_addr  output  16  read byte address.
REQ-011 mem_gnt  input  1  request accepted this cycle.
REQ-012 mem_rvalid  input  1  read data beat valid; beats return in request order.
REQ-013 mem_rdata  input  BUS_WIDTH_BYTES*8  read data beat.
REQ-014 row_data_o  output  BUS_WIDTH_BYTES*8  data beat to the array feeder.
REQ-015 row_valid_o  output  1  row_data_o valid.
REQ-016 row_ready_i  input  1  feeder accepts the beat.
REQ-017 row_index_o  output  log2(ARRAY_HEIGHT)  array row of the current output beat.
REQ-018 row_last_o  output  1  current output beat is the last of its row group.
REQ-019 busy_o  output  1  credit count nonzero or mem_req high.
REQ-020 err_o  output  1  sticky response-overflow error.

Function
REQ-021 Issue FSM states: IDLE and REQ.
REQ-022 IDLE: when a_fifo_empty=0 and credit<MAX_OUTSTANDING, assert a_fifo_pop, register a_fifo_addr into mem_addr, increment credit, and move to REQ; otherwise remain in IDLE with a_fifo_pop=0.
REQ-023 REQ: hold mem_req=1 and keep mem_addr stable until mem_gnt=1; a_fifo_pop=0 while mem_gnt=0.
REQ-024 REQ with mem_gnt=1: if a_fifo_empty=0 and credit (after any same-cycle return) <MAX_OUTSTANDING, pop, load the new address, increment credit and stay in REQ (back-to-back, one request per cycle); else go to IDLE.
REQ-025 mem_req is registered, is high only in REQ, and asserts one cycle after the pop.
REQ-026 Credit counter is log2(MAX_OUTSTANDING)+1 bits: +1 per pop, -1 per output handshake (row_valid_o&row_ready_i), net 0 on both in the same cycle; never exceeds MAX_OUTSTANDING, never underflows.
REQ-027 Response buffer is a MAX_OUTSTANDING-deep FIFO written on mem_rvalid; head drives row_data_o; row_valid_o = buffer not empty; zero-latency show-ahead (a beat written in cycle N is visible in cycle N+1).
REQ-028 Write and read of the buffer in the same cycle are both performed, including when the buffer is full.
REQ-029 mem_rvalid while the buffer is full and no read occurs that cycle: drop the beat and set err_o; err_o clears only on reset.
REQ-030 row_data_o is held stable while row_valid_o=1 and row_ready_i=0.
REQ-031 row_index_o counts output handshakes modulo ARRAY_HEIGHT, starting at 0.
REQ-032 row_last_o = row_valid_o & (row_index_o == ARRAY_HEIGHT-1).
REQ-033 Buffer pointers wrap modulo MAX_OUTSTANDING; the full/empty distinction uses an extra pointer bit.

Reset
REQ-034 On reset_n=0, asynchronously: FSM=IDLE, a_fifo_pop=0, mem_req=0, mem_addr=0, credit=0, buffer empty, row_valid_o=0, row_index_o=0, err_o=0.
REQ-035 Reset asserted mid-operation discards in-flight requests and buffered beats; beats arriving after reset are not protected by credit.
REQ-036 row_data_o after reset is don't-care; the bench checks it only when row_valid_o=1.

Verification
REQ-037 FIFO holds 0x0000, 0x0010, 0x0020, 0x0030; mem_gnt=1 always; data returned 2 cycles after grant; row_ready_i=1 -> mem_req high for 4 consecutive cycles with those addresses in order; 4 output beats in order; row_index_o 0,1,2,3; row_last_o on beat 4 only.
REQ-038 MAX_OUTSTANDING=4; 8 addresses queued; row_ready_i=0 -> exactly 4 pops, then a_fifo_pop=0 indefinitely; raising row_ready_i for one handshake -> exactly one further pop.
REQ-039 mem_gnt withheld 3 cycles on the first request -> mem_addr stable and mem_req=1 for 4 cycles; no further pop until the grant.
REQ-040 Credit full, buffer full, same-cycle output handshake and new pop -> credit stays at 4; no err_o.
REQ-041 Extra mem_rvalid injected with the buffer full and row_ready_i=0 -> err_o=1 and stays set; buffered data unchanged.
REQ-042 reset_n pulsed low with 2 requests in flight and 1 beat buffered -> all outputs at reset values in the same cycle; after release, a fresh 4-address burst behaves as in REQ-037.
